// File: rtl/ddr_wr_arb.sv
// -----------------------------------------------------------------------------
// ddr_wr_arb
//
// Merges CH_NUM line-write request ports from the video write buffers onto the
// single DDR controller write port. One burst is granted at a time, in
// round-robin order. The data strobe, ready and completion signals are steered
// back to the granted channel. Write data is steered from the granted channel
// to the controller. Everything runs in the ddr_clk domain.
//
// Optional feature (compile-time macro):
//   DDR_WR_ARB_TIMEOUT_EN - enables a watchdog. The watchdog counts REQ/DATA
//                           cycles that have no ddr_wdata_req. After
//                           TIMEOUT_CYCLES such cycles it aborts the burst:
//                           it sets tmo_err, pulses ch_wdone to the granted
//                           channel and returns to IDLE. Without the macro,
//                           tmo_err is tied to 0.
//
// Ports:
//   ddr_clk, ddr_rst     clock; synchronous active-high reset
//   ch_en                per-channel enable (disabled channels are never granted)
//   ch_wreq              per-channel burst request
//   ch_waddr, ch_wr_len  flattened per-channel start address / burst length
//   ch_wdata             flattened per-channel write data
//   ch_wrdy              ddr_wrdy routed to the granted channel
//   ch_wdata_req         ddr_wdata_req routed to the granted channel
//   ch_wdone             registered one-cycle completion pulse to the granted channel
//   ddr_wreq, ddr_waddr, ddr_wr_len   request to the DDR controller
//   ddr_wrdy, ddr_wdata_req, ddr_wdone controller handshake
//   ddr_wdata            write data selected from the granted channel
//   grant_id             current or last granted channel
//   busy                 high while in REQ or DATA
//   len_err              sticky: more beats than the latched length
//   tmo_err              sticky watchdog flag
// -----------------------------------------------------------------------------
module ddr_wr_arb #(
    parameter int CH_NUM         = 4,
    parameter int ADDR_WIDTH     = 27,
    parameter int LEN_WIDTH      = 16,
    parameter int DQ_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         ddr_clk,
    input  logic                         ddr_rst,
    input  logic [CH_NUM-1:0]            ch_en,
    input  logic [CH_NUM-1:0]            ch_wreq,
    input  logic [CH_NUM*ADDR_WIDTH-1:0] ch_waddr,
    input  logic [CH_NUM*LEN_WIDTH-1:0]  ch_wr_len,
    input  logic [CH_NUM*8*DQ_WIDTH-1:0] ch_wdata,
    output logic [CH_NUM-1:0]            ch_wrdy,
    output logic [CH_NUM-1:0]            ch_wdata_req,
    output logic [CH_NUM-1:0]            ch_wdone,
    output logic                         ddr_wreq,
    output logic [ADDR_WIDTH-1:0]        ddr_waddr,
    output logic [LEN_WIDTH-1:0]         ddr_wr_len,
    input  logic                         ddr_wrdy,
    input  logic                         ddr_wdata_req,
    input  logic                         ddr_wdone,
    output logic [8*DQ_WIDTH-1:0]        ddr_wdata,
    output logic [2:0]                   grant_id,
    output logic                         busy,
    output logic                         len_err,
    output logic                         tmo_err
);

    localparam int DW = 8 * DQ_WIDTH;

    // Reject unsupported configurations at elaboration time.
    if (CH_NUM < 2 || CH_NUM > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("ddr_wr_arb: CH_NUM must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [2:0]              grant_id_reg;
    logic [2:0]              rr_ptr_reg;
    logic                    ddr_wreq_reg;
    logic [ADDR_WIDTH-1:0]   ddr_waddr_reg;
    logic [LEN_WIDTH-1:0]    ddr_wr_len_reg;
    // One extra bit so an overrun by a full length still compares correctly.
    logic [LEN_WIDTH:0]      beat_cnt_reg;
    logic                    len_err_reg;
    logic [7:0]              ch_wdone_reg;
    // Cleared by reset so ddr_wdata reads 0 until the first grant.
    logic                    have_grant_reg;

    // Per-channel views padded to 8 entries, so that the 3-bit grant index
    // always selects a legal element.
    logic [DW-1:0]           wdata_arr [8];
    logic [ADDR_WIDTH-1:0]   waddr_arr [8];
    logic [LEN_WIDTH-1:0]    len_arr   [8];
    logic [7:0]              cand;

    logic                    route_en;
    logic                    pick_found;
    logic [2:0]              pick_idx;
    logic [3:0]              scan_idx;
    logic [2:0]              rr_ptr_next;
    logic [LEN_WIDTH:0]      beat_inc;
    logic                    beat_over;

    // ------------------------------------------------------------------
    // Unpack the flattened channel buses.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
        if (gi < CH_NUM) begin : g_ch
            assign wdata_arr[gi] = ch_wdata[gi*DW +: DW];
            assign waddr_arr[gi] = ch_waddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign len_arr[gi]   = ch_wr_len[gi*LEN_WIDTH +: LEN_WIDTH];
            assign cand[gi]      = ch_wreq[gi] & ch_en[gi];
        end else begin : g_pad
            assign wdata_arr[gi] = '0;
            assign waddr_arr[gi] = '0;
            assign len_arr[gi]   = '0;
            assign cand[gi]      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pick. The scan runs from the farthest offset down to
    // offset 0, so the candidate nearest to rr_ptr overwrites the others
    // and wins.
    // ------------------------------------------------------------------
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            scan_idx = {1'b0, rr_ptr_reg} + 4'(i);
            if (scan_idx >= 4'(CH_NUM)) begin
                scan_idx = scan_idx - 4'(CH_NUM);
            end
            if (cand[scan_idx[2:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[2:0];
            end
        end
    end

    assign rr_ptr_next = (pick_idx == 3'(CH_NUM - 1)) ? 3'd0 : pick_idx + 3'd1;

    // The beat count saturates, so that a runaway controller cannot wrap it
    // back below the latched length.
    assign beat_inc  = (&beat_cnt_reg) ? beat_cnt_reg : beat_cnt_reg + 1'b1;
    assign beat_over = beat_inc > {1'b0, ddr_wr_len_reg};

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
`ifdef DDR_WR_ARB_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_reg;
    logic              tmo_err_reg;
`endif

    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            state_reg      <= IDLE;
            grant_id_reg   <= '0;
            rr_ptr_reg     <= '0;
            ddr_wreq_reg   <= 1'b0;
            ddr_waddr_reg  <= '0;
            ddr_wr_len_reg <= '0;
            beat_cnt_reg   <= '0;
            len_err_reg    <= 1'b0;
            ch_wdone_reg   <= '0;
            have_grant_reg <= 1'b0;
`ifdef DDR_WR_ARB_TIMEOUT_EN
            wdog_reg       <= '0;
            tmo_err_reg    <= 1'b0;
`endif
        end else begin
            ch_wdone_reg <= '0;

            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        grant_id_reg   <= pick_idx;
                        ddr_waddr_reg  <= waddr_arr[pick_idx];
                        ddr_wr_len_reg <= len_arr[pick_idx];
                        beat_cnt_reg   <= '0;
                        ddr_wreq_reg   <= 1'b1;
                        rr_ptr_reg     <= rr_ptr_next;
                        have_grant_reg <= 1'b1;
                        state_reg      <= REQ;
                    end
                end

                // The first data strobe also acknowledges the request. Any
                // ddr_wdone seen before it is ignored.
                REQ: begin
                    if (ddr_wdata_req) begin
                        ddr_wreq_reg <= 1'b0;
                        beat_cnt_reg <= beat_inc;
                        if (beat_over) begin
                            len_err_reg <= 1'b1;
                        end
                        state_reg <= DATA;
                    end
                end

                // A beat and ddr_wdone can arrive in the same cycle. The beat
                // is counted and the burst still completes.
                DATA: begin
                    if (ddr_wdata_req) begin
                        beat_cnt_reg <= beat_inc;
                        if (beat_over) begin
                            len_err_reg <= 1'b1;
                        end
                    end
                    if (ddr_wdone) begin
                        ch_wdone_reg <= 8'b1 << grant_id_reg;
                        state_reg    <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase

`ifdef DDR_WR_ARB_TIMEOUT_EN
            // The watchdog overrides the FSM. It releases the stalled channel
            // with a completion pulse, so that its buffer is not blocked forever.
            if (state_reg == IDLE || ddr_wdata_req) begin
                wdog_reg <= '0;
            end else if (wdog_reg == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                wdog_reg     <= '0;
                tmo_err_reg  <= 1'b1;
                ddr_wreq_reg <= 1'b0;
                ch_wdone_reg <= 8'b1 << grant_id_reg;
                state_reg    <= IDLE;
            end else begin
                wdog_reg <= wdog_reg + 1'b1;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Output routing. This logic is combinational from the state register,
    // so strobes reach the channel with zero latency.
    // ------------------------------------------------------------------
    assign route_en = (state_reg != IDLE);

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_route
        assign ch_wdata_req[gi] = route_en && (grant_id_reg == 3'(gi)) && ddr_wdata_req;
        assign ch_wrdy[gi]      = route_en && (grant_id_reg == 3'(gi)) && ddr_wrdy;
    end

    assign ch_wdone   = ch_wdone_reg[CH_NUM-1:0];
    // After the burst, the data path stays on the last granted channel.
    assign ddr_wdata  = have_grant_reg ? wdata_arr[grant_id_reg] : '0;
    assign ddr_wreq   = ddr_wreq_reg;
    assign ddr_waddr  = ddr_waddr_reg;
    assign ddr_wr_len = ddr_wr_len_reg;
    assign grant_id   = grant_id_reg;
    assign busy       = route_en;
    assign len_err    = len_err_reg;

`ifdef DDR_WR_ARB_TIMEOUT_EN
    assign tmo_err = tmo_err_reg;
`else
    assign tmo_err = 1'b0;
`endif

endmodule

// File: doc/ddr_wr_arb.md
# ddr_wr_arb

Parametrised N-channel arbiter that merges the per-channel line-write request ports of the video write buffers onto the single DDR controller write port. Each buffer keeps its native handshake (`wreq`/`waddr`/`wr_len`/`wdata_req`/`wdone`). The arbiter grants one burst at a time in round-robin order and steers data, strobes and completion back to the granted channel. It sits between the write buffers and the DDR controller write interface, entirely in the `ddr_clk` domain.

## Interface
- `CH_NUM`, 4: number of write channels, 2..8.
- `ADDR_WIDTH`, 27: DDR address width.
- `LEN_WIDTH`, 16: burst length width, counted in `8*DQ_WIDTH`-bit beats.
- `DQ_WIDTH`, 16: DDR DQ width; the data bus is `8*DQ_WIDTH`.
- `TIMEOUT_CYCLES`, 4096: watchdog limit (only used with `DDR_WR_ARB_TIMEOUT_EN`).

Ports:
- `ddr_clk` in 1: single clock.
- `ddr_rst` in 1: synchronous reset, active-high.
- `ch_en` in CH_NUM: per-channel enable; a disabled channel is never granted.
- `ch_wreq` in CH_NUM: per-channel burst request, held until that channel's `ch_wdata_req`.
- `ch_waddr` in CH_NUM*ADDR_WIDTH: flattened start addresses; channel i occupies `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `ch_wr_len` in CH_NUM*LEN_WIDTH: flattened burst lengths.
- `ch_wdata` in CH_NUM*8*DQ_WIDTH: flattened write data.
- `ch_wrdy` out CH_NUM: `ddr_wrdy` routed to the granted channel.
- `ch_wdata_req` out CH_NUM: `ddr_wdata_req` routed to the granted channel.
- `ch_wdone` out CH_NUM: one-cycle completion pulse to the granted channel.
- `ddr_wreq` out 1, `ddr_waddr` out ADDR_WIDTH, `ddr_wr_len` out LEN_WIDTH: request to the controller.
- `ddr_wrdy` in 1, `ddr_wdata_req` in 1, `ddr_wdone` in 1: controller handshake.
- `ddr_wdata` out 8*DQ_WIDTH: data to the controller.
- `grant_id` out 3: index of the current or last granted channel.
- `busy` out 1: high in REQ and DATA.
- `len_err` out 1: sticky; set when beats exceed the latched length.
- `tmo_err` out 1: sticky watchdog flag; constant 0 without the macro.

## Operation
- FSM states: IDLE, REQ, DATA.
- **IDLE:**
  - Candidates are `ch_wreq & ch_en`.
  - Pick the first candidate searching from `rr_ptr`, wrapping modulo CH_NUM.
  - On a pick: latch `grant_id`, `ddr_waddr`, `ddr_wr_len`; clear the beat counter; set `ddr_wreq`=1; set `rr_ptr` = grant+1 (wraps to 0); go to REQ.
  - No candidate: stay in IDLE.
- **REQ:**
  - Hold `ddr_wreq` until `ddr_wdata_req`=1.
  - On that cycle: register `ddr_wreq`=0, count the first beat, go to DATA.
  - Changes on `ch_wreq`/`ch_en` after the grant are ignored; the granted burst always completes.
- **DATA:**
  - Each `ddr_wdata_req` cycle increments the beat counter.
  - Beat counter > latched `ddr_wr_len` sets `len_err`.
  - On `ddr_wdone`: pulse `ch_wdone[grant_id]`, go to IDLE.
- **Routing (combinational, valid in REQ and DATA):**
  - `ch_wdata_req[g]`=`ddr_wdata_req`, `ch_wrdy[g]`=`ddr_wrdy`, `ddr_wdata`=`ch_wdata[g]`.
  - Non-granted channels see 0.
  - In IDLE, `ddr_wdata` holds the last granted channel's data.
- **Simultaneous events:**
  - `ddr_wdone` in the same cycle as `ddr_wdata_req` in DATA: count the beat, then complete.
  - `ddr_wdone` in REQ: ignored.
- **Reset mid-burst:** FSM returns to IDLE, all outputs clear, no `ch_wdone` is issued; the channel restarts itself on its own frame sync.
- **Reset values:** `ddr_wreq`, `ddr_waddr`, `ddr_wr_len`, `ddr_wdata`, `ch_*` outputs, `grant_id`, `busy`, `len_err`, `tmo_err` all 0; `rr_ptr`=0.

## Timing
- Request latency: `ch_wreq` seen in IDLE in cycle n gives `ddr_wreq`=1 in cycle n+1.
- `ddr_wreq` deasserts the cycle after the first `ddr_wdata_req`.
- Strobes and data routing: zero latency, combinational from the FSM state register.
- `ch_wdone`: registered, one cycle after `ddr_wdone`.
- Back-to-back bursts: minimum one IDLE cycle between `ddr_wdone` and the next `ddr_wreq`.
- Fairness: with all channels requesting continuously, each channel is granted once every CH_NUM bursts.

## Configuration
- `DDR_WR_ARB_TIMEOUT_EN` defined:
  - A watchdog counts cycles in REQ and DATA and clears on each `ddr_wdata_req`.
  - On reaching TIMEOUT_CYCLES: set `tmo_err`, drop `ddr_wreq`, pulse `ch_wdone[grant_id]` so the channel unblocks, return to IDLE.
- Undefined: no watchdog logic; `tmo_err` is tied to 0 and the FSM waits indefinitely.

## Test plan
- **Single channel:** ch2 requests, addr 0x12000, len 160, controller issues 160 `wdata_req` then `wdone` → `ddr_waddr`=0x12000, `ddr_wr_len`=160, 160 strobes on `ch_wdata_req[2]` only, one `ch_wdone[2]` pulse, `len_err`=0.
- **All four channels requesting continuously:** grant order 0,1,2,3,0,…; exactly one IDLE cycle between bursts.
- **`ch_en`=4'b1011 with all requesting:** ch2 is never granted; order 0,1,3,0.
- **Length overrun:** len 4 but 5 `wdata_req` → `len_err`=1 after the 5th beat and stays set until `ddr_rst`.
- **Reset in DATA after 10 beats:** next cycle all outputs are 0 and no `ch_wdone`; the next grant goes to channel 0 first.
- **With `DDR_WR_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=64:** no `ddr_wdata_req` for 64 cycles → `tmo_err`=1, `ddr_wreq`=0, `ch_wdone` pulses, FSM back in IDLE.
